// File: rtl/rule_depacker_param.sv
// Splits wide rule beats into OUT_W lanes (optionally dropping all-zero lanes) and queues them
// in a first-word-fall-through FIFO; eop beats become a single terminator word.
module rule_depacker_param #(
  parameter int unsigned IN_W       = 512,
  parameter int unsigned OUT_W      = 256,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          SKIP_ZERO  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_rule_sop,
  input  logic                          in_rule_eop,
  input  logic                          in_rule_valid,
  input  logic [IN_W-1:0]               in_rule_data,
  input  logic [$clog2(IN_W/8)-1:0]     in_rule_empty,
  output logic                          in_rule_ready,
  output logic                          out_rule_sop,
  output logic                          out_rule_eop,
  output logic                          out_rule_valid,
  output logic [OUT_W-1:0]              out_rule_data,
  output logic [$clog2(OUT_W/8)-1:0]    out_rule_empty,
  input  logic                          out_rule_ready,
  output logic [31:0]                   stat_words_out,
  output logic [31:0]                   stat_lanes_skipped
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = OUT_W + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SPLIT = 2'd1;
  localparam logic [1:0] ST_TERM  = 2'd2;

  if ((IN_W % OUT_W) != 0 || RATIO < 2 || FIFO_DEPTH < 2 * RATIO ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("rule_depacker_param: illegal IN_W/OUT_W/FIFO_DEPTH combination");
  end

  logic [1:0]       state_q, state_d;
  logic [IN_W-1:0]  data_q, data_d;
  logic [RATIO-1:0] mask_q, mask_d;
  logic             sop_q, sop_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      words_q, words_d;
  logic [31:0]      skipped_q, skipped_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

  logic             accept;
  logic             pop;
  logic             push;
  logic [ENT_W-1:0] push_word;
  logic [RATIO-1:0] new_mask;
  logic [31:0]      zero_lanes;
  logic [OUT_W-1:0] lane_sel;
  logic [ENT_W-1:0] head;
  logic             unused_empty;

  assign unused_empty = ^in_rule_empty;
  assign accept       = in_rule_valid & ready_q;
  assign pop          = (count_q != '0) & out_rule_ready;

  // Lane presence mask for the incoming beat and the number of lanes it drops.
  always_comb begin
    new_mask   = '0;
    zero_lanes = '0;
    for (int i = 0; i < RATIO; i++) begin
      new_mask[i] = (in_rule_data[i*OUT_W +: OUT_W] != '0) | !SKIP_ZERO;
      zero_lanes  = zero_lanes + 32'(!new_mask[i]);
    end
  end

  // Lowest pending lane of the latched beat.
  always_comb begin
    lane_sel = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (mask_q[i]) lane_sel = data_q[i*OUT_W +: OUT_W];
    end
  end

  // Next-state and FIFO bookkeeping.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    sop_d     = sop_q;
    skipped_d = skipped_q;
    push      = 1'b0;
    push_word = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_rule_eop) begin
            sop_d   = in_rule_sop;
            state_d = ST_TERM;
          end else begin
            data_d    = in_rule_data;
            mask_d    = new_mask;
            skipped_d = skipped_q + zero_lanes;
            if (new_mask != '0) state_d = ST_SPLIT;
          end
        end
      end
      ST_SPLIT: begin
        push      = 1'b1;
        push_word = {2'b00, lane_sel};
        mask_d    = mask_q & (mask_q - RATIO'(1));
        if (mask_d == '0) state_d = ST_IDLE;
      end
      ST_TERM: begin
        push      = 1'b1;
        push_word = {sop_q, 1'b1, {OUT_W{1'b0}}};
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        mask_d  = '0;
      end
    endcase

    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    words_d  = words_q + 32'(pop);
    // A beat is only taken when a whole beat's worth of lanes fits.
    ready_d  = (state_d == ST_IDLE) &&
               ((CNT_W'(FIFO_DEPTH) - count_d) >= CNT_W'(RATIO));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      mask_q    <= '0;
      sop_q     <= 1'b0;
      ready_q   <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      words_q   <= '0;
      skipped_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      sop_q     <= sop_d;
      ready_q   <= ready_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      words_q   <= words_d;
      skipped_q <= skipped_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // Head of the FIFO, gated so an empty FIFO presents all-zero outputs.
  assign head               = mem_q[rd_ptr_q];
  assign out_rule_valid     = (count_q != '0);
  assign out_rule_data      = out_rule_valid ? head[OUT_W-1:0] : '0;
  assign out_rule_eop       = out_rule_valid & head[OUT_W];
  assign out_rule_sop       = out_rule_valid & head[OUT_W+1];
  assign out_rule_empty     = '0;
  assign in_rule_ready      = ready_q;
  assign stat_words_out     = words_q;
  assign stat_lanes_skipped = skipped_q;

endmodule

// File: tb/tb_rule_depacker_param.sv
// Randomized and directed bench for rule_depacker_param against a lane-queue reference model.
module tb_rule_depacker_param;

  localparam int unsigned IN_W  = 512;
  localparam int unsigned OUT_W = 256;
  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_sop, in_eop, in_valid, in_valid_nz;
  logic [IN_W-1:0]  in_data;
  logic [5:0]       in_empty;
  logic             in_ready, in_ready_nz;
  logic             out_sop, out_eop, out_valid;
  logic             out_sop_nz, out_eop_nz, out_valid_nz;
  logic [OUT_W-1:0] out_data, out_data_nz;
  logic [4:0]       out_empty, out_empty_nz;
  logic             out_ready;
  logic             out_ready_nz;
  logic [31:0]      st_words, st_skip, st_words_nz, st_skip_nz;

  rule_depacker_param #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH), .SKIP_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_rule_sop(in_sop), .in_rule_eop(in_eop), .in_rule_valid(in_valid),
    .in_rule_data(in_data), .in_rule_empty(in_empty), .in_rule_ready(in_ready),
    .out_rule_sop(out_sop), .out_rule_eop(out_eop), .out_rule_valid(out_valid),
    .out_rule_data(out_data), .out_rule_empty(out_empty), .out_rule_ready(out_ready),
    .stat_words_out(st_words), .stat_lanes_skipped(st_skip)
  );

  rule_depacker_param #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH), .SKIP_ZERO(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n),
    .in_rule_sop(in_sop), .in_rule_eop(in_eop), .in_rule_valid(in_valid_nz),
    .in_rule_data(in_data), .in_rule_empty(in_empty), .in_rule_ready(in_ready_nz),
    .out_rule_sop(out_sop_nz), .out_rule_eop(out_eop_nz), .out_rule_valid(out_valid_nz),
    .out_rule_data(out_data_nz), .out_rule_empty(out_empty_nz), .out_rule_ready(out_ready_nz),
    .stat_words_out(st_words_nz), .stat_lanes_skipped(st_skip_nz)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [271:0] got, input logic [271:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected words {sop,eop,data} plus statistic counters.
  logic [OUT_W+1:0] exp_q[$];
  logic [31:0]      m_skip = 0;
  logic [31:0]      m_words = 0;

  task automatic model_beat(input logic [IN_W-1:0] d, input logic s, input logic e);
    logic [OUT_W-1:0] lane;
    if (e) begin
      exp_q.push_back({s, 1'b1, {OUT_W{1'b0}}});
    end else begin
      for (int i = 0; i < RATIO; i++) begin
        lane = d[i*OUT_W +: OUT_W];
        if (lane != '0) exp_q.push_back({2'b00, lane});
        else m_skip = m_skip + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [OUT_W+1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_skip  = 0;
      m_words = 0;
    end else begin
      if (out_valid && out_ready) begin
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("pop_word", {out_sop, out_eop, out_data}, e);
        m_words = m_words + 1;
      end
      if (in_valid && in_ready) model_beat(in_data, in_sop, in_eop);
    end
  end

  logic ready_mode = 1'b0;
  logic ready_force = 1'b1;
  always @(posedge clk) begin
    #1 out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  function automatic logic [OUT_W-1:0] rand_lane();
    logic [OUT_W-1:0] l;
    for (int k = 0; k < OUT_W / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic send_beat(input logic [IN_W-1:0] d, input logic s, input logic e);
    int n = 0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin n++; @(negedge clk); end
    if (!in_ready) chk("in_ready_timeout", 272'(in_ready), 272'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin n++; @(negedge clk); end
    repeat (3) @(negedge clk);
    chk("drain_left", 272'(exp_q.size()), 272'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [IN_W-1:0]  d;
    logic [OUT_W+1:0] held;
    int               n_acc, pops;
    logic             acc;
    logic [OUT_W-1:0] lane_a, lane_b, lane_c;

    in_sop = 0; in_eop = 0; in_valid = 0; in_valid_nz = 0; in_data = '0; in_empty = '0;
    out_ready = 1'b1; out_ready_nz = 1'b1;
    lane_a = {64{4'hA}}; lane_b = {64{4'hB}}; lane_c = {64{4'hC}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 272'(in_ready), 0);
    chk("rst_out_valid", {out_sop, out_eop, out_valid}, 0);
    chk("rst_out_data", 272'(out_data), 0);
    chk("rst_stats", {st_words, st_skip}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_pre", 272'(in_ready), 0);
    @(negedge clk);
    chk("ready_post", 272'(in_ready), 272'(1));
    chk("out_empty", 272'(out_empty), 0);

    // Two nonzero lanes: words at N+2 and N+3.
    @(posedge clk); #1;
    send_beat({lane_b, lane_a}, 1'b0, 1'b0);
    @(negedge clk); chk("lat_n1_valid", 272'(out_valid), 0);
    @(negedge clk); chk("lat_n2_word", {out_valid, out_sop, out_eop, out_data}, {3'b100, lane_a});
    @(negedge clk); chk("lat_n3_word", {out_valid, out_sop, out_eop, out_data}, {3'b100, lane_b});
    wait_drain();
    chk("words_two", 272'(st_words), 272'(2));

    // Zero low lane, then all-zero beat.
    @(posedge clk); #1;
    send_beat({lane_c, {OUT_W{1'b0}}}, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); chk("skip_word", {out_valid, out_data}, {1'b1, lane_c});
    wait_drain();
    chk("skip_one", 272'(st_skip), 272'(1));
    @(posedge clk); #1;
    send_beat('0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("zero_beat_valid", 272'(out_valid), 0);
    chk("skip_three", 272'(st_skip), 272'(3));
    chk("words_three", 272'(st_words), 272'(3));

    // eop beat becomes a single terminator word.
    @(posedge clk); #1;
    send_beat({IN_W{1'b1}}, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk); chk("term_word", {out_valid, out_sop, out_eop, out_data}, {3'b111, {OUT_W{1'b0}}});
    wait_drain();
    chk("words_four", 272'(st_words), 272'(4));

    // Non-skipping instance emits zero lanes.
    @(posedge clk); #1;
    in_data = '0; in_sop = 0; in_eop = 0; in_valid_nz = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 in_valid_nz = 1'b0;
    pops = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_nz) begin
        pops++;
        chk("nz_word", {out_sop_nz, out_eop_nz, out_data_nz}, 0);
      end
    end
    chk("nz_pops", 272'(pops), 272'(2));
    chk("nz_skip", 272'(st_skip_nz), 0);
    chk("nz_words", 272'(st_words_nz), 272'(2));

    // Backpressure fills the FIFO exactly.
    @(posedge clk); #1 ready_force = 1'b0;
    @(posedge clk); #1;
    n_acc = 0; in_sop = 0; in_eop = 0;
    for (int i = 0; i < RATIO; i++) in_data[i*OUT_W +: OUT_W] = {8{32'(n_acc*2 + i + 1)}};
    in_valid = 1'b1;
    repeat (80) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        for (int i = 0; i < RATIO; i++) in_data[i*OUT_W +: OUT_W] = {8{32'(n_acc*2 + i + 1)}};
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_beats", 272'(n_acc), 272'(DEPTH / RATIO));
    chk("bp_in_ready", 272'(in_ready), 0);
    chk("bp_queued", 272'(exp_q.size()), 272'(DEPTH));
    held = {out_sop, out_eop, out_data};
    repeat (5) @(negedge clk);
    chk("bp_hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, held});
    @(posedge clk); #1 ready_force = 1'b1;
    wait_drain();
    chk("bp_words", 272'(st_words), 272'(m_words));

    // Reset in the middle of a split.
    @(posedge clk); #1;
    send_beat({lane_b, lane_a}, 1'b0, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 272'(out_valid), 0);
    chk("rst_mid_stats", {st_words, st_skip}, 0);
    repeat (2) @(negedge clk);
    chk("rst_mid_ready", 272'(in_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_word", 272'(out_valid), 0);
    @(posedge clk); #1;
    send_beat({lane_c, lane_a}, 1'b0, 1'b0);
    wait_drain();
    chk("rst_after_words", 272'(st_words), 272'(2));

    // Randomized traffic with random backpressure.
    @(posedge clk); #1 ready_mode = 1'b1;
    for (int b = 0; b < 150; b++) begin
      for (int i = 0; i < RATIO; i++)
        d[i*OUT_W +: OUT_W] = ($urandom_range(0, 2) == 0) ? '0 : rand_lane();
      send_beat(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    @(posedge clk); #1 ready_mode = 1'b0; ready_force = 1'b1;
    wait_drain();
    chk("rand_words", 272'(st_words), 272'(m_words));
    chk("rand_skip", 272'(st_skip), 272'(m_skip));
    chk("rand_idle_valid", 272'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
